// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the mem_bridge SRAM controller
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int WAIT_STATES_MAX = 7;

endpackage

// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - core fetch/data ports and SRAM pins of mem_bridge
interface mem_bridge_if #(
  parameter int ADDR_W = 20
);
  logic              inst_ce_i;
  logic [31:0]       inst_addr_i;
  logic [31:0]       inst_data_o;
  logic              inst_ready_o;

  logic              data_ce_i;
  logic              data_we_i;
  logic [3:0]        data_sel_i;
  logic [31:0]       data_addr_i;
  logic [31:0]       data_data_i;
  logic [31:0]       data_data_o;
  logic              data_ready_o;

  logic              stall_o;

  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_data_o;
  logic [31:0]       sram_data_i;
  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic              sram_we_n_o;
  logic [3:0]        sram_be_n_o;

  // master: the core plus the SRAM device; slave: the bridge itself
  modport master (
    output inst_ce_i, inst_addr_i,
    output data_ce_i, data_we_i, data_sel_i, data_addr_i, data_data_i,
    input  inst_data_o, inst_ready_o, data_data_o, data_ready_o, stall_o,
    input  sram_addr_o, sram_data_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
    output sram_data_i
  );

  modport slave (
    input  inst_ce_i, inst_addr_i,
    input  data_ce_i, data_we_i, data_sel_i, data_addr_i, data_data_i,
    output inst_data_o, inst_ready_o, data_data_o, data_ready_o, stall_o,
    output sram_addr_o, sram_data_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o,
    input  sram_data_i
  );

endinterface

// File: rtl/mem_bridge_ibuf.sv
// rtl/mem_bridge_ibuf.sv - one-entry instruction buffer (valid, word tag, data) for mem_bridge
module mem_bridge_ibuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [31:0]       data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [31:0]       fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr
);
  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [31:0]       word;

  assign hit  = valid && (tag == lookup_addr);
  assign data = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      word  <= fill_data;
    end else if (inval && (inval_addr == tag)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - fetch/data arbiter onto one async SRAM; MEM_BRIDGE_INST_BUF_EN adds an instruction buffer
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  mem_bridge_if.slave bus
);
  localparam int         WAIT_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT_EFF);

  state_t            state, state_nx;
  logic [2:0]        cnt;
  logic              port, sel_port;
  logic              we_lat, we_nx;
  logic              start, hit_take;
  logic              last_access;
  logic [ADDR_W-1:0] req_addr;
  logic              ibuf_hit;
  logic [31:0]       ibuf_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.inst_addr_i[31:ADDR_W+2], bus.inst_addr_i[1:0],
                              bus.data_addr_i[31:ADDR_W+2], bus.data_addr_i[1:0]};

  assign bus.stall_o = (bus.inst_ce_i & ~bus.inst_ready_o) | (bus.data_ce_i & ~bus.data_ready_o);

  assign last_access = (state == ACCESS) && (cnt == 3'd0);
  assign req_addr    = (sel_port == PORT_DATA) ? bus.data_addr_i[ADDR_W+1:2]
                                               : bus.inst_addr_i[ADDR_W+1:2];
  assign we_nx       = start ? ((sel_port == PORT_DATA) && bus.data_we_i) : we_lat;

`ifdef MEM_BRIDGE_INST_BUF_EN
  mem_bridge_ibuf #(.ADDR_W(ADDR_W)) u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (bus.inst_addr_i[ADDR_W+1:2]),
    .hit         (ibuf_hit),
    .data        (ibuf_data),
    .fill        (last_access && (port == PORT_INST)),
    .fill_addr   (bus.sram_addr_o),
    .fill_data   (bus.sram_data_i),
    .inval       ((state == DONE) && (port == PORT_DATA) && we_lat),
    .inval_addr  (bus.sram_addr_o)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  // Data port always wins in IDLE; a buffered fetch skips ACCESS entirely
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    hit_take = 1'b0;
    sel_port = PORT_INST;
    case (state)
      IDLE: begin
        if (bus.data_ce_i) begin
          sel_port = PORT_DATA;
          start    = 1'b1;
          state_nx = ACCESS;
        end else if (bus.inst_ce_i && ibuf_hit) begin
          hit_take = 1'b1;
          state_nx = DONE;
        end else if (bus.inst_ce_i) begin
          start    = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS:  if (cnt == 3'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      port             <= PORT_INST;
      we_lat           <= 1'b0;
      bus.sram_ce_n_o  <= 1'b1;
      bus.sram_oe_n_o  <= 1'b1;
      bus.sram_we_n_o  <= 1'b1;
      bus.sram_be_n_o  <= 4'hF;
      bus.sram_addr_o  <= '0;
      bus.sram_data_o  <= '0;
      bus.inst_ready_o <= 1'b0;
      bus.data_ready_o <= 1'b0;
      bus.inst_data_o  <= '0;
      bus.data_data_o  <= '0;
    end else begin
      state            <= state_nx;
      we_lat           <= we_nx;
      bus.inst_ready_o <= 1'b0;
      bus.data_ready_o <= 1'b0;
      // Strobes are registered from the next state so they line up with ACCESS
      bus.sram_ce_n_o  <= !(state_nx == ACCESS);
      bus.sram_oe_n_o  <= !((state_nx == ACCESS) && !we_nx);
      bus.sram_we_n_o  <= !((state_nx == ACCESS) && we_nx);

      if (start) begin
        cnt             <= WAIT_CNT;
        port            <= sel_port;
        bus.sram_addr_o <= req_addr;
        bus.sram_be_n_o <= (sel_port == PORT_DATA) ? ~bus.data_sel_i : 4'b0000;
        if (sel_port == PORT_DATA) bus.sram_data_o <= bus.data_data_i;
      end else if ((state == ACCESS) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end

      if (last_access) begin
        if (port == PORT_DATA) begin
          bus.data_ready_o <= 1'b1;
          if (!we_lat) bus.data_data_o <= bus.sram_data_i;
        end else begin
          bus.inst_ready_o <= 1'b1;
          bus.inst_data_o  <= bus.sram_data_i;
        end
      end

      if (hit_take) begin
        port             <= PORT_INST;
        bus.inst_ready_o <= 1'b1;
        bus.inst_data_o  <= ibuf_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - vector table and scoreboard bench for mem_bridge at WAIT_STATES 1, 0 and 7
module tb_mem_bridge;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          inst;
    bit          is_data;
    bit          we;
    logic [3:0]  bsel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [19:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] erd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          sel;
  logic        inst_ce, data_ce, data_we;
  logic [3:0]  data_sel;
  logic [31:0] inst_addr, data_addr, data_wdata;

  logic        o_ce_n [3], o_oe_n [3], o_we_n [3], o_ir [3], o_dr [3], o_stall [3];
  logic [3:0]  o_be_n [3];
  logic [19:0] o_addr [3];
  logic [31:0] o_wdata [3], o_idata [3], o_ddata [3];

  exp_t sb[$];
  vec_t vec [15];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ce, n_oe, n_we;
  logic [19:0] seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_bridge_if #(.ADDR_W(20)) bus ();
    logic [31:0] mem [256];

    assign bus.inst_ce_i   = inst_ce && (sel == k);
    assign bus.inst_addr_i = inst_addr;
    assign bus.data_ce_i   = data_ce && (sel == k);
    assign bus.data_we_i   = data_we;
    assign bus.data_sel_i  = data_sel;
    assign bus.data_addr_i = data_addr;
    assign bus.data_data_i = data_wdata;
    assign bus.sram_data_i = (!bus.sram_ce_n_o && !bus.sram_oe_n_o) ? mem[bus.sram_addr_o[7:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (!bus.sram_ce_n_o && !bus.sram_we_n_o) begin
        for (int b = 0; b < 4; b++)
          if (!bus.sram_be_n_o[b]) mem[bus.sram_addr_o[7:0]][8*b +: 8] <= bus.sram_data_o[8*b +: 8];
      end
    end

    mem_bridge #(.WAIT_STATES((k == 0) ? 1 : ((k == 1) ? 0 : 7)), .ADDR_W(20)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign o_ce_n[k]  = bus.sram_ce_n_o;
    assign o_oe_n[k]  = bus.sram_oe_n_o;
    assign o_we_n[k]  = bus.sram_we_n_o;
    assign o_be_n[k]  = bus.sram_be_n_o;
    assign o_addr[k]  = bus.sram_addr_o;
    assign o_wdata[k] = bus.sram_data_o;
    assign o_ir[k]    = bus.inst_ready_o;
    assign o_dr[k]    = bus.data_ready_o;
    assign o_idata[k] = bus.inst_data_o;
    assign o_ddata[k] = bus.data_data_o;
    assign o_stall[k] = bus.stall_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Watch the selected DUT until the wanted ready pulses arrive; drop each ce the cycle after its ready
  task automatic run(input bit want_d, input bit want_i, input int stall_until);
    bit   dd, di;
    exp_t e;
    dd = !want_d;
    di = !want_i;
    n_ce = 0; n_oe = 0; n_we = 0;
    for (int n = 0; n < 40 && !(dd && di); n++) begin
      @(negedge clk);
      if (!o_ce_n[sel]) begin n_ce++; seen_addr = o_addr[sel]; seen_be = o_be_n[sel]; end
      if (!o_oe_n[sel]) n_oe++;
      if (!o_we_n[sel]) begin n_we++; seen_wd = o_wdata[sel]; end
      if (stall_until >= 0) check("stall", 64'(o_stall[sel]), 64'(cyc < stall_until));
      if (o_dr[sel] || o_ir[sel]) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'({o_dr[sel], o_ir[sel]}), 64'd0);
        end else begin
          e = sb.pop_front();
          check("ready_port", 64'(o_dr[sel]), 64'(e.is_data));
          check("ready_cycle", 64'(cyc), 64'(e.cyc));
          if (e.chk) check("read_data", 64'(e.is_data ? o_ddata[sel] : o_idata[sel]), 64'(e.data));
        end
      end
      if (o_dr[sel]) dd = 1'b1;
      if (o_ir[sel]) di = 1'b1;
      @(posedge clk); #1;
      if (dd) data_ce = 1'b0;
      if (di) inst_ce = 1'b0;
    end
    if (!(dd && di)) begin
      check("ready_timeout", 64'({dd, di}), 64'(2'b11));
      data_ce = 1'b0;
      inst_ce = 1'b0;
    end
  endtask

  task automatic transact(input bit do_d, input bit do_i, input bit we, input logic [3:0] bsel,
                          input logic [31:0] daddr, input logic [31:0] wdata, input logic [31:0] iaddr,
                          input logic [31:0] dexp, input logic [31:0] iexp,
                          input int dlat, input int ilat, input int stall_rel);
    exp_t e;
    @(posedge clk); #1;
    data_ce = do_d; inst_ce = do_i; data_we = we; data_sel = bsel;
    data_addr = daddr; data_wdata = wdata; inst_addr = iaddr;
    if (do_d) begin e.is_data = 1'b1; e.chk = !we; e.data = dexp; e.cyc = cyc + dlat; sb.push_back(e); end
    if (do_i) begin e.is_data = 1'b0; e.chk = 1'b1; e.data = iexp; e.cyc = cyc + ilat; sb.push_back(e); end
    run(do_d, do_i, (stall_rel < 0) ? -1 : cyc + stall_rel);
  endtask

  initial begin
    int   w;
    int   t;
    int   quiet_ce, quiet_rdy;
    vec_t v;

    //           inst data we  sel    addr          wdata         eaddr    ebe    erd
    vec[0]  = '{0, 1, 0, 4'hF, 32'h00000010, 32'h0,        20'h04, 4'h0, 32'hDEADBEEF};
    vec[1]  = '{0, 1, 1, 4'h3, 32'h00000020, 32'h11223344, 20'h08, 4'hC, 32'h0};
    vec[2]  = '{0, 1, 0, 4'hF, 32'h00000020, 32'h0,        20'h08, 4'h0, 32'hC0DE3344};
    vec[3]  = '{0, 0, 0, 4'h5, 32'h00000030, 32'h0,        20'h0C, 4'h0, 32'hC0DE000C};
    vec[4]  = '{0, 1, 0, 4'hF, 32'hFFC00013, 32'h0,        20'h04, 4'h0, 32'hDEADBEEF};
    vec[5]  = '{0, 1, 1, 4'hF, 32'h00000044, 32'hA5A55A5A, 20'h11, 4'h0, 32'h0};
    vec[6]  = '{0, 1, 1, 4'h0, 32'h00000044, 32'hFFFFFFFF, 20'h11, 4'hF, 32'h0};
    vec[7]  = '{0, 0, 0, 4'hA, 32'h00000044, 32'h0,        20'h11, 4'h0, 32'hA5A55A5A};
    vec[8]  = '{0, 1, 1, 4'hA, 32'h00000048, 32'hAABBCCDD, 20'h12, 4'h5, 32'h0};
    vec[9]  = '{0, 1, 0, 4'hF, 32'h00000048, 32'h0,        20'h12, 4'h0, 32'hAADECC12};
    vec[10] = '{1, 1, 0, 4'hF, 32'h00000010, 32'h0,        20'h04, 4'h0, 32'hDEADBEEF};
    vec[11] = '{1, 0, 0, 4'h0, 32'h000003FC, 32'h0,        20'hFF, 4'h0, 32'hC0DE00FF};
    vec[12] = '{2, 1, 0, 4'hF, 32'h00000008, 32'h0,        20'h02, 4'h0, 32'hC0DE0002};
    vec[13] = '{2, 1, 1, 4'hC, 32'h00000008, 32'h12345678, 20'h02, 4'h3, 32'h0};
    vec[14] = '{2, 0, 0, 4'h0, 32'h00000008, 32'h0,        20'h02, 4'h0, 32'h12340002};

    rst = 1'b1; sel = 0;
    inst_ce = 1'b0; data_ce = 1'b0; data_we = 1'b0; data_sel = 4'h0;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check("reset_outputs",
            64'({o_ce_n[k], o_oe_n[k], o_we_n[k], o_be_n[k], o_addr[k], o_wdata[k], o_ir[k], o_dr[k], o_stall[k]}),
            64'({3'b111, 4'hF, 20'h0, 32'h0, 3'b000}));
      check("reset_read_data", {o_idata[k], o_ddata[k]}, 64'h0);
    end

    for (int i = 0; i < 15; i++) begin
      v   = vec[i];
      sel = v.inst;
      w   = wait_of(v.inst);
      transact(v.is_data, !v.is_data, v.we, v.bsel, v.addr, v.wdata, v.addr,
               v.erd, v.erd, 2 + w, 2 + w, -1);
      check("sram_addr", 64'(seen_addr), 64'(v.eaddr));
      check("sram_be_n", 64'(seen_be), 64'(v.ebe));
      check("ce_cycles", 64'(n_ce), 64'(w + 1));
      check("oe_cycles", 64'(n_oe), 64'(v.we ? 0 : w + 1));
      check("we_cycles", 64'(n_we), 64'(v.we ? w + 1 : 0));
      if (v.we) check("sram_wdata", 64'(seen_wd), 64'(v.wdata));
    end

    // Fetch and data read raised together at W=0: data at t+2, fetch at t+5
    sel = 1;
    transact(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h30, 32'hDEADBEEF, 32'hC0DE000C, 2, 5, 5);

    // Instruction buffer sequence on the W=1 instance
    sel = 0;
    transact(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'hC0DE0040, 0, 3, -1);
    check("ibuf_fill_ce", 64'(n_ce), 64'd2);
`ifdef MEM_BRIDGE_INST_BUF_EN
    transact(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'hC0DE0040, 0, 1, -1);
    check("ibuf_hit_ce", 64'(n_ce), 64'd0);
    transact(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h100, 32'hDEADBEEF, 32'hC0DE0040, 3, 5, -1);
    check("ibuf_prio_ce", 64'(n_ce), 64'd2);
`else
    transact(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'hC0DE0040, 0, 3, -1);
    check("refetch_ce", 64'(n_ce), 64'd2);
    transact(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h100, 32'hDEADBEEF, 32'hC0DE0040, 3, 7, -1);
    check("prio_ce", 64'(n_ce), 64'd4);
`endif
    transact(1'b1, 1'b0, 1'b1, 4'hF, 32'h100, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 3, 0, -1);
    transact(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0BADF00D, 0, 3, -1);
    check("refetch_after_write_ce", 64'(n_ce), 64'd2);

    // W=7 read aborted by reset in its fourth ACCESS cycle
    sel = 2;
    @(posedge clk); #1;
    data_ce = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h0000000C;
    t = cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("w7_mid_access_oe", 64'({o_ce_n[2], o_oe_n[2]}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("w7_reset_cycle", 64'(cyc), 64'(t + 4));
    @(posedge clk); #1;
    data_ce = 1'b0;
    @(negedge clk);
    check("reset_abort_strobes", 64'({o_ce_n[2], o_oe_n[2], o_we_n[2], o_ir[2], o_dr[2], o_addr[2]}),
          64'({5'b11100, 20'h0}));
    @(posedge clk); #1;
    rst = 1'b0;
    quiet_ce = 0; quiet_rdy = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (!o_ce_n[2]) quiet_ce++;
      if (o_ir[2] || o_dr[2]) quiet_rdy++;
    end
    check("post_abort_ce", 64'(quiet_ce), 64'd0);
    check("post_abort_ready", 64'(quiet_rdy), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Single-port SRAM controller between the GeMIPS core and one external asynchronous 32-bit SRAM. It sits directly downstream of the core's instruction-fetch port (rom_addr/ce/data) and data port (ram2_*). It arbitrates both ports onto the one SRAM, inserts configurable wait states, and returns per-port ready pulses plus a pipeline stall.

## Interface
Parameters:
- WAIT_STATES, 1: extra SRAM cycles per access; legal range 0..7.
- ADDR_W, 20: SRAM word-address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_ce_i  in  1  instruction request; held until inst_ready_o.
- inst_addr_i  in  32  byte address of the fetch.
- inst_data_o  out  32  fetched word; valid while inst_ready_o=1.
- inst_ready_o  out  1  one-cycle completion pulse for the fetch.
- data_ce_i  in  1  data request; held until data_ready_o.
- data_we_i  in  1  1 = write, 0 = read.
- data_sel_i  in  4  byte lanes.
- data_addr_i  in  32  byte address.
- data_data_i  in  32  write data.
- data_data_o  out  32  read word; always the full word (the core extracts bytes); valid while data_ready_o=1.
- data_ready_o  out  1  one-cycle completion pulse for the data access.
- stall_o  out  1  (inst_ce_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o); combinational.
- sram_addr_o  out  ADDR_W  word address = addr[ADDR_W+1:2].
- sram_data_o  out  32  write data driven to the SRAM.
- sram_data_i  in  32  read data from the SRAM.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes.
- sram_be_n_o  out  4  active-low byte enables: ~data_sel_i for data accesses, 4'b0000 for fetches.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If data_ce_i, latch the data request and go to ACCESS.
  - Else if inst_ce_i, latch the fetch and go to ACCESS.
  - Data always wins. A pending fetch is served after the data access's DONE.
- ACCESS lasts WAIT_STATES+1 cycles, counted by a 3-bit down-counter.
  - Address, byte enables and write data are held from latched values.
  - sram_ce_n_o=0 throughout.
  - Read: sram_oe_n_o=0. Write: sram_we_n_o=0.
  - Read data is captured from sram_data_i on the final ACCESS cycle.
- DONE, one cycle:
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o return high.
  - Address and write data stay held, giving write hold time.
  - The ready pulse of the served port is asserted.
  - Next state is IDLE.
- If a requester drops ce mid-access, the access still completes and the ready pulse still fires. The core must ignore it.
- A request still high in the IDLE cycle after ready is treated as a new access.
- Reset values: state IDLE, counter 0, all *_n outputs high, sram_addr_o/sram_data_o 0, both ready 0, inst_data_o/data_data_o 0.
- Reset mid-ACCESS aborts in the next cycle. A partially written SRAM word is accepted.

## Timing
- Request first seen in IDLE at cycle t:
  - ACCESS occupies t+1 .. t+1+WAIT_STATES.
  - Ready is asserted at t+2+WAIT_STATES.
- Throughput: one access per WAIT_STATES+3 cycles.
- Simultaneous fetch and data request at t: data ready at t+2+W; fetch ready at t+2·(W+3)−1.
- Outputs are registered except stall_o.

## Configuration
- MEM_BRIDGE_INST_BUF_EN defined:
  - One-entry instruction buffer holds a valid bit, word-address tag and data.
  - A fetch that hits in IDLE asserts inst_ready_o in the next cycle with the buffered word. No SRAM cycle is started.
  - Each SRAM fetch refills the buffer.
  - Any data write whose word address equals the tag clears the valid bit in its DONE cycle.
  - Reset clears the valid bit.
  - A data request in IDLE still has priority over a buffer hit.
- Not defined: every fetch performs an SRAM access; no buffer logic is present.

## Structure
- Package mem_bridge_pkg holds:
  - state enum (IDLE/ACCESS/DONE);
  - port-select constants (PORT_INST, PORT_DATA);
  - WAIT_STATES legal maximum (7).
- Sub-module mem_bridge_ibuf: the instruction buffer. It is instantiated only under MEM_BRIDGE_INST_BUF_EN.

## Test plan
- Reset, W=1, then read of data at 0x0000_0010 with SRAM word 4 = 0xDEADBEEF → sram_addr_o=4, oe_n low 2 cycles, data_ready_o at t+3, data_data_o=0xDEADBEEF.
- Write 0x11223344 to 0x0000_0020 with sel=4'b0011 → be_n=4'b1100, we_n low 2 cycles, SRAM word 8 bytes 1:0 = 0x3344, bytes 3:2 unchanged.
- Fetch and data read raised in the same cycle, W=0 → data_ready_o at t+2, inst_ready_o at t+5, stall_o high until t+5.
- W=7 read → ACCESS lasts 8 cycles, ready at t+9; rst asserted at t+4 → next cycle all strobes high, no ready pulse.
- With MEM_BRIDGE_INST_BUF_EN: fetch 0x100 twice.
  - Second fetch → inst_ready_o 1 cycle after request, ce_n stays high.
  - Then write word 0x100 and fetch again → full SRAM access with the new data.
